// File: rtl/i2c_scl_phase_gen.sv
// I2C SCL/data-clock phase generator: four programmable quarters per SCL period,
// phase strobes, slave clock-stretch detection with a masked window and a stretch timeout.
module i2c_scl_phase_gen #(
  parameter int DIV_W        = 16,
  parameter int TO_W         = 20,
  parameter int STRETCH_MASK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [TO_W-1:0]  stretch_to,
  input  logic             scl_in,
  output logic             scl_clk,
  output logic             data_clk,
  output logic [1:0]       phase,
  output logic             stretch_range,
  output logic             period_tick,
  output logic             data_rise_tick,
  output logic             scl_rise_tick,
  output logic             data_fall_tick,
  output logic             stretching,
  output logic             timeout_err,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_STRETCH = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [DIV_W-1:0] qcnt_q, qcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TO_W-1:0]  scnt_q, scnt_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       tick_q, tick_d;
  logic             scl_q, scl_d;
  logic             data_q, data_d;
  logic             range_q, range_d;
  logic             stretching_q, stretching_d;
  logic             busy_q, busy_d;

  logic [DIV_W-1:0] div_eff;
  logic             q_end;
  logic             stretch_req;
  logic             advance;
  logic             run_like;

  assign div_eff     = (div == '0) ? DIV_W'(1) : div;
  assign q_end       = (qcnt_q == div_q - DIV_W'(1));
  // The first STRETCH_MASK cycles of phase 2 hide our own SCL release still travelling through the pad.
  assign stretch_req = (phase_q == 2'd2) && (qcnt_q >= DIV_W'(STRETCH_MASK)) && !scl_in;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    qcnt_d    = qcnt_q;
    div_d     = div_q;
    scnt_d    = scnt_q;
    timeout_d = timeout_q;
    tick_d    = 4'b0000;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_RUN;
          phase_d   = 2'd0;
          qcnt_d    = '0;
          div_d     = div_eff;
          tick_d[0] = 1'b1;
        end
      end
      S_RUN: begin
        if (stretch_req) begin
          state_d = S_STRETCH;
          scnt_d  = TO_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      S_STRETCH: begin
        // A release in the same cycle as the timeout takes priority.
        if (scl_in) begin
          state_d = S_RUN;
          scnt_d  = '0;
          advance = 1'b1;
        end else if ((stretch_to != '0) && (scnt_q == stretch_to)) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
        end else if (scnt_q != '1) begin
          scnt_d = scnt_q + TO_W'(1);
        end
      end
      default: begin
        if (!en) begin
          state_d   = S_IDLE;
          timeout_d = 1'b0;
          phase_d   = 2'd3;
          qcnt_d    = '0;
          scnt_d    = '0;
        end
      end
    endcase

    if (advance) begin
      if (!q_end) begin
        qcnt_d = qcnt_q + DIV_W'(1);
      end else begin
        qcnt_d = '0;
        if (phase_q == 2'd3 && !en) begin
          state_d = S_IDLE;
          phase_d = 2'd3;
        end else begin
          phase_d         = phase_q + 2'd1;
          tick_d[phase_d] = 1'b1;
          if (phase_q == 2'd3) div_d = div_eff;
        end
      end
    end

    run_like     = (state_d == S_RUN) || (state_d == S_STRETCH);
    scl_d        = run_like ? phase_d[1] : 1'b1;
    data_d       = run_like ? (phase_d[1] ^ phase_d[0]) : 1'b0;
    range_d      = run_like && (phase_d == 2'd2);
    stretching_d = (state_d == S_STRETCH);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 2'd3;
      qcnt_q       <= '0;
      div_q        <= DIV_W'(1);
      scnt_q       <= '0;
      timeout_q    <= 1'b0;
      tick_q       <= 4'b0000;
      scl_q        <= 1'b1;
      data_q       <= 1'b0;
      range_q      <= 1'b0;
      stretching_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      qcnt_q       <= qcnt_d;
      div_q        <= div_d;
      scnt_q       <= scnt_d;
      timeout_q    <= timeout_d;
      tick_q       <= tick_d;
      scl_q        <= scl_d;
      data_q       <= data_d;
      range_q      <= range_d;
      stretching_q <= stretching_d;
      busy_q       <= busy_d;
    end
  end

  assign scl_clk        = scl_q;
  assign data_clk       = data_q;
  assign phase          = phase_q;
  assign stretch_range  = range_q;
  assign period_tick    = tick_q[0];
  assign data_rise_tick = tick_q[1];
  assign scl_rise_tick  = tick_q[2];
  assign data_fall_tick = tick_q[3];
  assign stretching     = stretching_q;
  assign timeout_err    = timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// Bench for i2c_scl_phase_gen: expected strobe (kind, cycle) pairs are queued per scenario
// and matched by a monitor as the strobes appear; levels are checked at known cycles.
module tb_i2c_scl_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic [19:0] stretch_to;
  logic        scl_in;
  logic        scl_clk, data_clk, stretch_range, stretching, timeout_err, busy;
  logic [1:0]  phase;
  logic        period_tick, data_rise_tick, scl_rise_tick, data_fall_tick;

  i2c_scl_phase_gen #(.DIV_W(16), .TO_W(20), .STRETCH_MASK(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .stretch_to(stretch_to), .scl_in(scl_in),
    .scl_clk(scl_clk), .data_clk(data_clk), .phase(phase), .stretch_range(stretch_range),
    .period_tick(period_tick), .data_rise_tick(data_rise_tick), .scl_rise_tick(scl_rise_tick),
    .data_fall_tick(data_fall_tick), .stretching(stretching), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int cyc; } exp_t;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   base    = 0;
  logic force_low = 1'b0;
  logic [3:0] mon_t;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic push(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic push_period(input int start, input int d);
    for (int k = 0; k < 4; k++) push(k, start + k * d);
  endtask

  task automatic drive_scl();
    scl_in = force_low ? 1'b0 : scl_clk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_scl();
  endtask

  task automatic step_to(input int k);
    while (cyc - base < k) step();
  endtask

  task automatic start_run(input int d, input int to);
    base       = cyc;
    div        = 16'(d);
    stretch_to = 20'(to);
    en         = 1'b1;
    $display("[TB] run start div=%0d stretch_to=%0d", d, to);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_scl"}, int'(scl_clk), 1);
    check({tag, "_data"}, int'(data_clk), 0);
    check({tag, "_phase"}, int'(phase), 3);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_stretching"}, int'(stretching), 0);
    check({tag, "_timeout"}, int'(timeout_err), 0);
  endtask

  task automatic check_phase(input string tag, input int p, input int s, input int d);
    check({tag, "_phase"}, int'(phase), p);
    check({tag, "_scl"}, int'(scl_clk), s);
    check({tag, "_data"}, int'(data_clk), d);
    check({tag, "_range"}, int'(stretch_range), (p == 2) ? 1 : 0);
  endtask

  // Strobe monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    mon_t = {data_fall_tick, scl_rise_tick, data_rise_tick, period_tick};
    for (int k = 0; k < 4; k++) begin
      if (mon_t[k] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("extra_tick%0d", k), cyc - base, -1);
        end else begin
          mon_e = sb_q.pop_front();
          check("tick_kind", k, mon_e.kind);
          check("tick_cyc", cyc - base, mon_e.cyc);
          $display("[TB] tick kind=%0d at rel cycle %0d (exp kind=%0d cycle %0d)",
                   k, cyc - base, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; div = 16'd4; stretch_to = 20'd0; scl_in = 1'b1;
    repeat (3) step();
    check_idle("reset");
    check("reset_range", int'(stretch_range), 0);
    check("reset_ticks", int'({data_fall_tick, scl_rise_tick, data_rise_tick, period_tick}), 0);
    rst = 1'b0;
    repeat (2) step();
    check_idle("idle");

    // Basic periods, then en dropped mid phase 1 of the second period.
    push_period(1, 4);
    push_period(17, 4);
    start_run(4, 0);
    step_to(2);  check_phase("p0", 0, 0, 0); check("p0_busy", int'(busy), 1);
    step_to(6);  check_phase("p1", 1, 0, 1);
    step_to(10); check_phase("p2", 2, 1, 1);
    step_to(14); check_phase("p3", 3, 1, 0);
    step_to(22); en = 1'b0;
    step_to(32); check("last_busy", int'(busy), 1); check("last_phase", int'(phase), 3);
    step_to(33); check_idle("stop");
    step_to(40); check("sb_empty_basic", sb_q.size(), 0);

    // Ten-cycle stretch from phase-2 qcnt=2, then masked low pulse in a later period.
    push(0, 1); push(1, 5); push(2, 9); push(3, 23);
    push_period(27, 4);
    push_period(43, 4);
    start_run(4, 0);
    step_to(11); force_low = 1'b1; drive_scl(); check("st_pre", int'(stretching), 0);
    step_to(12); check("st_first", int'(stretching), 1);
    step_to(21); check("st_last", int'(stretching), 1); check("st_phase", int'(phase), 2);
    check("st_scl", int'(scl_clk), 1); check("st_data", int'(data_clk), 1);
    force_low = 1'b0; drive_scl();
    step_to(22); check("st_released", int'(stretching), 0);
    step_to(44); en = 1'b0;
    step_to(51); force_low = 1'b1; drive_scl();
    step_to(52); check("mask_q1", int'(stretching), 0);
    step_to(53); check("mask_q2", int'(stretching), 0); force_low = 1'b0; drive_scl();
    step_to(59); check("st_idle_busy", int'(busy), 0);
    step_to(62); check("sb_empty_stretch", sb_q.size(), 0);

    // Stuck-low SCL with an 8-cycle timeout.
    push(0, 1); push(1, 5); push(2, 9);
    start_run(4, 8);
    step_to(9);  force_low = 1'b1; drive_scl();
    step_to(19); check("to_pre_stretch", int'(stretching), 1); check("to_pre_err", int'(timeout_err), 0);
    step_to(20); check("to_err", int'(timeout_err), 1); check("to_data", int'(data_clk), 0);
    check("to_busy", int'(busy), 1); check("to_stretching", int'(stretching), 0);
    check("to_scl", int'(scl_clk), 1);
    step_to(25); check("to_sticky", int'(timeout_err), 1); en = 1'b0;
    step_to(26); check_idle("to_idle");
    force_low = 1'b0; drive_scl();
    step_to(30); check("sb_empty_timeout", sb_q.size(), 0);

    // Divisor changes take effect only at the wrap; div=0 acts as 1.
    push_period(1, 4);
    push_period(17, 2);
    push_period(25, 2);
    push_period(33, 1);
    push_period(37, 1);
    start_run(4, 0);
    step_to(3);  div = 16'd2;
    step_to(26); div = 16'd0;
    step_to(38); en = 1'b0;
    step_to(40); check("div1_busy", int'(busy), 1);
    step_to(41); check_idle("div_idle");
    step_to(45); check("sb_empty_div", sb_q.size(), 0);

    // Reset asserted mid-stretch, en held so the generator restarts.
    push(0, 1); push(1, 5); push(2, 9);
    push_period(16, 4);
    start_run(4, 0);
    step_to(11); force_lo_set();
    step_to(14); check("rs_stretch", int'(stretching), 1); rst = 1'b1;
    step_to(15); check_idle("rs_reset"); check("rs_range", int'(stretch_range), 0);
    rst = 1'b0; force_low = 1'b0; drive_scl();
    step_to(16); check("rs_restart_busy", int'(busy), 1); check("rs_restart_phase", int'(phase), 0);
    step_to(17); en = 1'b0;
    step_to(32); check_idle("rs_final");
    step_to(36); check("sb_empty_reset", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic force_lo_set();
    force_low = 1'b1;
    drive_scl();
  endtask

endmodule

// File: doc/i2c_scl_phase_gen.md
Name: i2c_scl_phase_gen

Overview:
- Parametrised successor to the fixed-divider I2C SCL/data-clock generator.
- Produces the four-quarter SCL period with `scl_clk`, `data_clk` and phase strobes.
- Quarter length is programmable at runtime. Start/stop is gated by `en`.
- Supports slave clock stretching with a masked sampling window, plus a programmable stretch timeout with a sticky error flag.
- Sits between the I2C master byte FSM (consumes the strobes) and the SCL open-drain pad logic.

Parameters:
- DIV_W, 16: width of the runtime quarter-period divisor and of the quarter counter.
- TO_W, 20: width of the stretch-timeout value and of the stretch counter.
- STRETCH_MASK, 2: number of initial phase-2 cycles in which `scl_in` is ignored (covers pad plus synchroniser latency). Must be < minimum used `div`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run request; level sensitive
- div  in  DIV_W  quarter-period length in clk cycles; 0 is treated as 1
- stretch_to  in  TO_W  stretch timeout in cycles; 0 disables the timeout
- scl_in  in  1  synchronised sampled SCL bus level
- scl_clk  out  1  SCL drive level (1 = release)
- data_clk  out  1  data-phase clock
- phase  out  2  current quarter, 0..3
- stretch_range  out  1  high while phase == 2
- period_tick  out  1  1-cycle pulse on first cycle of phase 0
- data_rise_tick  out  1  1-cycle pulse on first cycle of phase 1
- scl_rise_tick  out  1  1-cycle pulse on first cycle of phase 2
- data_fall_tick  out  1  1-cycle pulse on first cycle of phase 3
- stretching  out  1  high while the counter is frozen by a stretch
- timeout_err  out  1  sticky stretch-timeout flag
- busy  out  1  high in any state other than IDLE

Behaviour:

Registers and reset
- All outputs are registered.
- Reset values: state = IDLE, `scl_clk` = 1, `data_clk` = 0, `phase` = 3, `stretch_range` = 0, all ticks = 0, `stretching` = 0, `timeout_err` = 0, `busy` = 0, quarter counter `qcnt` = 0, stretch counter `scnt` = 0.
- `rst` overrides everything, including mid-period and mid-stretch.

Phase output encoding
- Phase 0: `scl_clk` = 0, `data_clk` = 0.
- Phase 1: `scl_clk` = 0, `data_clk` = 1.
- Phase 2: `scl_clk` = 1, `data_clk` = 1.
- Phase 3: `scl_clk` = 1, `data_clk` = 0.

Divisor latch
- `div_q` = max(`div`, 1).
- Latched on the IDLE→RUN transition and on each phase-3→phase-0 wrap.
- Changes to `div` mid-period have no effect until the next wrap.

FSM states and transitions
- IDLE: outputs hold their idle values (as at reset). If `en` = 1, the next cycle is RUN with phase 0, `qcnt` = 0, `period_tick` = 1. Startup latency is exactly 1 cycle.
- RUN:
  - `qcnt` increments each cycle.
  - When `qcnt` = `div_q`−1, `qcnt` → 0 and phase advances; that phase's tick pulses on the following cycle.
  - Each phase lasts exactly `div_q` cycles when not stretched; one period = 4·`div_q`.
  - At the end of phase 3: if `en` = 0, go to IDLE (scl=1, data=0, phase=3). Otherwise wrap to phase 0.
  - `en` deassertion is honoured only at the period boundary. The current period always completes.
- RUN, phase 2: if `qcnt` ≥ STRETCH_MASK and `scl_in` = 0, go to STRETCH. In that cycle `qcnt` does not increment and `scnt` = 1.
- STRETCH:
  - `qcnt` frozen, `stretching` = 1, `scl_clk` = 1, `data_clk` = 1, phase = 2.
  - `scnt` increments each cycle, saturating at its maximum.
  - If `scl_in` = 1, return to RUN. `qcnt` resumes from its frozen value in the same cycle, `stretching` → 0, `scnt` → 0.
  - Else if `stretch_to` ≠ 0 and `scnt` = `stretch_to`, go to TIMEOUT.
- TIMEOUT:
  - `timeout_err` = 1 (sticky), `scl_clk` = 1, `data_clk` = 0, `stretching` = 0, no ticks, `busy` = 1.
  - Leaves only on `rst`, or on `en` = 0 → IDLE with `timeout_err` cleared on entering IDLE.
- `scl_in` is ignored outside phase 2.
- If `scl_in` releases in the same cycle that the timeout would fire, the release wins.

Test Plan:
- rst, then `div` = 4, `en` = 1, `scl_in` follows `scl_clk` → `period_tick` at cycle 1. Phases last 4 cycles each; period = 16 cycles. `data_rise_tick` / `scl_rise_tick` / `data_fall_tick` at cycles 5 / 9 / 13. Next `period_tick` at cycle 17.
- `div` = 4; hold `scl_in` = 0 for 10 cycles starting at phase-2 `qcnt` = 2 → `stretching` high for 10 cycles. Phase 2 lasts 14 cycles; the period is 26 cycles; the period after it returns to 16.
- `div` = 4, `stretch_to` = 8, `scl_in` stuck 0 → after 8 stretch cycles: `timeout_err` = 1, `data_clk` = 0, `busy` = 1. Then `en` = 0 → IDLE next cycle, `timeout_err` = 0.
- Drop `en` in the middle of phase 1 → phases 1–3 complete, then IDLE (`busy` = 0, `scl_clk` = 1, phase = 3). No `period_tick`.
- Change `div` 4→2 mid-period → the current period stays 16 cycles; the next period is 8 cycles. `div` = 0 → behaves as 1, giving a 4-cycle period.
- Assert `rst` during STRETCH → the next cycle shows the reset values for all outputs; `en` held at 1 restarts with `period_tick` one cycle after `rst` drops.
